// File: rtl/uart_msg_tx.sv
// UART message transmitter: N-entry byte buffer serialised as start/data/[parity]/stop frames.
// Optional even parity bit is enabled by defining UART_MSG_TX_PARITY_EN.
module uart_msg_tx #(
  parameter int D   = 234,
  parameter int L   = 8,
  parameter int N   = 4,
  parameter int GAP = 0,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int LW = $clog2(N + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [L-1:0]  i_wr_data,
  input  logic [LW-1:0] i_len,
  input  logic          i_start,
  input  logic          i_repeat,
  output logic          o_txd,
  output logic          o_busy,
  output logic          o_done
);

  localparam int BDW = (D > 1) ? $clog2(D) : 1;
  localparam int BW  = $clog2(L);
  localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_GAP
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [BDW-1:0]  baud_cnt_r, baud_nxt_s;
  logic [BW-1:0]   bit_cnt_r, bit_nxt_s;
  logic [GW-1:0]   gap_cnt_r, gap_nxt_s;
  logic [AW-1:0]   idx_r, idx_nxt_s;
  logic [LW-1:0]   len_r, len_nxt_s;
  logic [L-1:0]    shift_r, shift_nxt_s;
  logic            txd_r, txd_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            done_r, done_nxt_s;
  logic [L-1:0]    buf_r [N];
  logic [AW:0]     wr_addr_ext_s;
  logic [LW:0]     len_ext_s;
  logic            baud_last_s, bit_last_s, gap_last_s, last_char_s;

`ifdef UART_MSG_TX_PARITY_EN
  logic            parity_r, parity_nxt_s;

  function automatic logic parity_f(input logic [L-1:0] data);
    return ^data;
  endfunction
`endif

  assign wr_addr_ext_s = {1'b0, i_wr_addr};
  assign len_ext_s     = {1'b0, i_len};
  assign baud_last_s   = (baud_cnt_r == BDW'(D - 1));
  assign bit_last_s    = (bit_cnt_r == BW'(L - 1));
  assign gap_last_s    = (gap_cnt_r == GW'(GAP - 1));
  assign last_char_s   = ((LW'(idx_r) + LW'(1)) == len_r);

  // Message buffer write port; out-of-range addresses are dropped, contents survive reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (wr_addr_ext_s < (AW + 1)'(N))) begin
      buf_r[i_wr_addr] <= i_wr_data;
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_nxt_s = state_r;
    bit_nxt_s   = bit_cnt_r;
    gap_nxt_s   = gap_cnt_r;
    idx_nxt_s   = idx_r;
    len_nxt_s   = len_r;
    shift_nxt_s = shift_r;
    txd_nxt_s   = txd_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
`ifdef UART_MSG_TX_PARITY_EN
    parity_nxt_s = parity_r;
`endif
    if (state_r == ST_IDLE || baud_last_s) begin
      baud_nxt_s = {BDW{1'b0}};
    end else begin
      baud_nxt_s = baud_cnt_r + BDW'(1);
    end

    case (state_r)
      ST_IDLE: begin
        if (i_start && (i_len != {LW{1'b0}})) begin
          len_nxt_s   = (len_ext_s > (LW + 1)'(N)) ? LW'(N) : i_len;
          idx_nxt_s   = {AW{1'b0}};
          shift_nxt_s = buf_r[0];
`ifdef UART_MSG_TX_PARITY_EN
          parity_nxt_s = parity_f(buf_r[0]);
`endif
          txd_nxt_s   = 1'b0;
          busy_nxt_s  = 1'b1;
          state_nxt_s = ST_START;
        end else begin
          txd_nxt_s = 1'b1;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          bit_nxt_s   = {BW{1'b0}};
          txd_nxt_s   = shift_r[0];
          state_nxt_s = ST_DATA;
        end else begin
          txd_nxt_s = 1'b0;
        end
      end
      ST_DATA: begin
        if (baud_last_s && bit_last_s) begin
`ifdef UART_MSG_TX_PARITY_EN
          txd_nxt_s   = parity_r;
          state_nxt_s = ST_PARITY;
`else
          txd_nxt_s   = 1'b1;
          state_nxt_s = ST_STOP;
`endif
        end else if (baud_last_s) begin
          bit_nxt_s   = bit_cnt_r + BW'(1);
          shift_nxt_s = shift_r >> 1;
          txd_nxt_s   = shift_r[1];
        end else begin
          txd_nxt_s = shift_r[0];
        end
      end
`ifdef UART_MSG_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last_s) begin
          txd_nxt_s   = 1'b1;
          state_nxt_s = ST_STOP;
        end else begin
          txd_nxt_s = parity_r;
        end
      end
`endif
      ST_STOP: begin
        if (baud_last_s && last_char_s && !i_repeat) begin
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
          txd_nxt_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (baud_last_s) begin
          // Either the next character or, in repeat mode, a fresh pass from entry 0
          done_nxt_s = last_char_s;
          idx_nxt_s  = last_char_s ? {AW{1'b0}} : (idx_r + AW'(1));
          if (GAP == 0) begin
            shift_nxt_s = buf_r[idx_nxt_s];
`ifdef UART_MSG_TX_PARITY_EN
            parity_nxt_s = parity_f(buf_r[idx_nxt_s]);
`endif
            txd_nxt_s   = 1'b0;
            state_nxt_s = ST_START;
          end else begin
            gap_nxt_s   = {GW{1'b0}};
            txd_nxt_s   = 1'b1;
            state_nxt_s = ST_GAP;
          end
        end else begin
          txd_nxt_s = 1'b1;
        end
      end
      ST_GAP: begin
        if (baud_last_s && gap_last_s) begin
          shift_nxt_s = buf_r[idx_r];
`ifdef UART_MSG_TX_PARITY_EN
          parity_nxt_s = parity_f(buf_r[idx_r]);
`endif
          txd_nxt_s   = 1'b0;
          state_nxt_s = ST_START;
        end else if (baud_last_s) begin
          gap_nxt_s = gap_cnt_r + GW'(1);
        end else begin
          txd_nxt_s = 1'b1;
        end
      end
      default: begin
        txd_nxt_s   = 1'b1;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered line outputs; reset forces the line idle at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= {BDW{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      gap_cnt_r  <= {GW{1'b0}};
      idx_r      <= {AW{1'b0}};
      len_r      <= {LW{1'b0}};
      shift_r    <= {L{1'b0}};
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef UART_MSG_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_nxt_s;
      bit_cnt_r  <= bit_nxt_s;
      gap_cnt_r  <= gap_nxt_s;
      idx_r      <= idx_nxt_s;
      len_r      <= len_nxt_s;
      shift_r    <= shift_nxt_s;
      txd_r      <= txd_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
`ifdef UART_MSG_TX_PARITY_EN
      parity_r   <= parity_nxt_s;
`endif
    end
  end

  assign o_txd  = txd_r;
  assign o_busy = busy_r;
  assign o_done = done_r;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx with D=4, L=8, N=4, GAP=1; honours UART_MSG_TX_PARITY_EN.
module tb_uart_msg_tx;

`ifdef UART_MSG_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] len;
  logic       start;
  logic       rpt;
  logic       txd, busy, done;

  int compared   = 0;
  int mismatched = 0;
  int n          = 0;
  int sch_start  = -1;
  int sch_wa     = -1;
  int sch_wb     = -1;
  int sch_drop   = -1;
  logic [1:0] wa_addr, wb_addr;
  logic [7:0] wa_data, wb_data;
  logic [7:0] mbuf [4];

  uart_msg_tx #(.D(4), .L(8), .N(4), .GAP(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_len(len), .i_start(start), .i_repeat(rpt),
    .o_txd(txd), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s at n=%0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  // One cycle: apply scheduled stimulus at this negedge, then move to the next negedge
  task automatic adv();
    start = 1'b0;
    wr_en = 1'b0;
    if (n == sch_start) start = 1'b1;
    if (n == sch_wa) begin
      wr_en = 1'b1; wr_addr = wa_addr; wr_data = wa_data; mbuf[wa_addr] = wa_data;
    end
    if (n == sch_wb) begin
      wr_en = 1'b1; wr_addr = wb_addr; wr_data = wb_data; mbuf[wb_addr] = wb_data;
    end
    if (n == sch_drop) rpt = 1'b0;
    @(negedge clk);
    n++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; mbuf[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic launch(input logic [2:0] l);
    len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
  endtask

  task automatic check_frame(input logic [7:0] b);
    logic [10:0] fv;
`ifdef UART_MSG_TX_PARITY_EN
    fv = {1'b1, ^b, b, 1'b0};
`else
    fv = {1'b0, 1'b1, b, 1'b0};
`endif
    for (int k = 0; k < FB; k++) begin
      for (int j = 0; j < 4; j++) begin
        chk("txd_frame", {7'd0, txd}, {7'd0, fv[k]});
        chk("busy_frame", {7'd0, busy}, 8'd1);
        chk("done_frame", {7'd0, done}, 8'd0);
        adv();
      end
    end
  endtask

  task automatic check_idle_high(input int cycles, input logic busy_exp);
    for (int j = 0; j < cycles; j++) begin
      chk("txd_high", {7'd0, txd}, 8'd1);
      chk("busy_high", {7'd0, busy}, {7'd0, busy_exp});
      chk("done_high", {7'd0, done}, 8'd0);
      adv();
    end
  endtask

  // Checks one message pass; frame bytes are taken from the model buffer when each frame starts
  task automatic check_msg(input int nchars, input logic repeat_exp);
    logic [7:0] b;
    for (int c = 0; c < nchars; c++) begin
      b = mbuf[c];
      check_frame(b);
      if (c < nchars - 1) check_idle_high(4, 1'b1);
    end
    chk("done_end", {7'd0, done}, 8'd1);
    chk("busy_end", {7'd0, busy}, {7'd0, repeat_exp});
    chk("txd_end", {7'd0, txd}, 8'd1);
    adv();
    check_idle_high(3, repeat_exp);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
    len = 3'd0; start = 1'b0; rpt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_txd", {7'd0, txd}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-character message: 'A' then 'B', done 84 clocks after the first start bit
    wr(2'd0, 8'h41); wr(2'd1, 8'h42); wr(2'd2, 8'h43); wr(2'd3, 8'h44);
    launch(3'd2);
    check_msg(2, 1'b0);
    chk("msg2_len", n[7:0], (FB == 10) ? 8'd88 : 8'd96);

    // Zero length is ignored
    launch(3'd0);
    check_idle_high(12, 1'b0);

    // Length 7 clamps to 4; start while busy ignored; in-flight and later writes
    sch_start = 60;
    sch_wa = 10; wa_addr = 2'd0; wa_data = 8'hA5;
    sch_wb = 30; wb_addr = 2'd3; wb_data = 8'h3C;
    launch(3'd7);
    mbuf[0] = 8'h41;
    check_msg(4, 1'b0);
    mbuf[0] = 8'hA5;
    sch_start = -1; sch_wa = -1; sch_wb = -1;
    check_idle_high(4, 1'b0);

    // Repeat mode: second pass starts 44 clocks later, dropping repeat ends after it
    wr(2'd0, 8'h55);
    rpt = 1'b1;
    sch_drop = (FB == 10) ? 50 : 54;
    launch(3'd1);
    check_msg(1, 1'b1);
    chk("rpt_period", n[7:0], (FB == 10) ? 8'd44 : 8'd48);
    check_msg(1, 1'b0);
    sch_drop = -1;
    check_idle_high(8, 1'b0);

    // Reset during data bit 3 of 'A'
    wr(2'd0, 8'h41);
    launch(3'd1);
    while (n < 17) adv();
    chk("pre_rst_txd", {7'd0, txd}, 8'd0);
    chk("pre_rst_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_txd", {7'd0, txd}, 8'd1);
    chk("async_rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    check_idle_high(3, 1'b0);
    launch(3'd1);
    check_msg(1, 1'b0);

`ifdef UART_MSG_TX_PARITY_EN
    // 0x43 carries odd weight, so its even-parity bit is 1
    wr(2'd0, 8'h43);
    launch(3'd1);
    check_msg(1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
